// File: rtl/gpio_pio_irq_pkg.sv
// Shared constants for the Avalon-MM parallel I/O block: register map
// offsets and the edge-capture mode enumeration.
package gpio_pio_irq_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_DIR      = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK  = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP  = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  typedef enum logic [1:0] {
    EDGE_RISING  = 2'd0,
    EDGE_FALLING = 2'd1,
    EDGE_ANY     = 2'd2
  } edge_type_e;

endpackage

// File: rtl/gpio_pio_irq_edge.sv
// Per-bit input synchroniser, one-cycle delay flop and edge detector,
// vectorised across all WIDTH pins.
module gpio_pio_irq_edge
  import gpio_pio_irq_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter edge_type_e  EDGE_TYPE   = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] edge_out
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  dly_q;
  logic [SYNC_STAGES:0]              armed_q;
  logic [WIDTH-1:0]                  edge_sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      dly_q   <= '0;
      armed_q <= '0;
    end else begin
      sync_q[0] <= pin_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      dly_q   <= sync_q[SYNC_STAGES-1];
      armed_q <= {armed_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_comb begin
    edge_sel = '0;
    case (EDGE_TYPE)
      EDGE_RISING:  edge_sel = sync_out & ~dly_q;
      EDGE_FALLING: edge_sel = ~sync_out & dly_q;
      EDGE_ANY:     edge_sel = sync_out ^ dly_q;
      default:      edge_sel = '0;
    endcase
  end

  // Detection waits until the delay flop holds a real post-reset pin sample,
  // so pins held high across reset release do not look like rising edges.
  assign edge_out = armed_q[SYNC_STAGES] ? edge_sel : '0;

endmodule

// File: rtl/gpio_pio_irq.sv
// Avalon-MM parallel I/O port with per-bit direction, set/clear output
// access, synchronised inputs, edge capture and a masked level interrupt.
module gpio_pio_irq
  import gpio_pio_irq_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter edge_type_e       EDGE_TYPE   = EDGE_RISING,
  parameter int unsigned      SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe_port,
  output logic             irq
);

  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] direction;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] ec_clear;
  logic [31:0]      rd_next;
  logic             wr_en;
  logic             unused_writedata;

  assign wr_en            = chipselect & ~write_n;
  assign wd               = writedata[WIDTH-1:0];
  assign unused_writedata = ^writedata;
  assign ec_clear         = (wr_en && address == ADDR_EDGECAP) ? wd : '0;

  gpio_pio_irq_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_edge (
    .clk      (clk),
    .reset    (reset),
    .pin_in   (in_port),
    .sync_out (sync_in),
    .edge_out (edge_det)
  );

  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA:    rd_next[WIDTH-1:0] = (data_out & direction) | (sync_in & ~direction);
      ADDR_DIR:     rd_next[WIDTH-1:0] = direction;
      ADDR_IRQMASK: rd_next[WIDTH-1:0] = irqmask;
      ADDR_EDGECAP: rd_next[WIDTH-1:0] = edgecapture;
      default:      rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out    <= RESET_VALUE;
      direction   <= '0;
      irqmask     <= '0;
      edgecapture <= '0;
      readdata    <= '0;
      irq         <= 1'b0;
    end else begin
      if (wr_en) begin
        case (address)
          ADDR_DATA:     data_out  <= wd;
          ADDR_OUTSET:   data_out  <= data_out | wd;
          ADDR_OUTCLEAR: data_out  <= data_out & ~wd;
          ADDR_DIR:      direction <= wd;
          ADDR_IRQMASK:  irqmask   <= wd;
          default:       ;
        endcase
      end
      // A new edge is ORed in after the clear so a coincident set wins.
      edgecapture <= (edgecapture & ~ec_clear) | edge_det;
      irq         <= |(edgecapture & irqmask);
      readdata    <= rd_next;
    end
  end

  assign out_port = data_out;
  assign oe_port  = direction;

endmodule

// File: tb/tb_gpio_pio_irq.sv
// Directed self-checking bench: an 8-bit RISING instance and a 32-bit ANY
// instance share the bus; each task checks one feature with fixed vectors.
module tb_gpio_pio_irq;

  logic        clk;
  logic        reset;
  logic [2:0]  address;
  logic        cs8;
  logic        cs32;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in8;
  logic [31:0] in32;
  logic [31:0] rd8;
  logic [31:0] rd32;
  logic [7:0]  out8;
  logic [7:0]  oe8;
  logic [31:0] out32;
  logic [31:0] oe32;
  logic        irq8;
  logic        irq32;

  int passed;
  int total;

  gpio_pio_irq u_dut8 (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (cs8),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in8),
    .readdata   (rd8),
    .out_port   (out8),
    .oe_port    (oe8),
    .irq        (irq8)
  );

  gpio_pio_irq #(
    .WIDTH       (32),
    .RESET_VALUE (32'h1234_5678),
    .EDGE_TYPE   (gpio_pio_irq_pkg::EDGE_ANY),
    .SYNC_STAGES (2)
  ) u_dut32 (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (cs32),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in32),
    .readdata   (rd32),
    .out_port   (out32),
    .oe_port    (oe32),
    .irq        (irq32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; the write lands on the next posedge and the task
  // returns on the following negedge.
  task automatic bus_write(input logic sel32, input logic [2:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    cs8       = ~sel32;
    cs32      = sel32;
    write_n   = 1'b0;
    @(negedge clk);
    cs8     = 1'b0;
    cs32    = 1'b0;
    write_n = 1'b1;
  endtask

  task automatic bus_read(input logic sel32, input logic [2:0] a, output logic [31:0] d);
    address = a;
    @(negedge clk);
    d = sel32 ? rd32 : rd8;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    total++; if (out8 !== 8'h00) $display("FAIL reset_out8 got %h exp 00", out8); else passed++;
    total++; if (oe8 !== 8'h00) $display("FAIL reset_oe8 got %h exp 00", oe8); else passed++;
    total++; if (irq8 !== 1'b0) $display("FAIL reset_irq8 got %b exp 0", irq8); else passed++;
    total++; if (rd8 !== 32'h0) $display("FAIL reset_rd8 got %h exp 0", rd8); else passed++;
    total++; if (out32 !== 32'h1234_5678) $display("FAIL reset_out32 got %h exp 12345678", out32); else passed++;
    total++; if (rd32 !== 32'h0) $display("FAIL reset_rd32 got %h exp 0", rd32); else passed++;
  endtask

  task automatic test_data_ops;
    logic [31:0] d;
    bus_write(0, 3'd0, 32'h0000_00A5);
    total++; if (out8 !== 8'hA5) $display("FAIL data_load got %h exp a5", out8); else passed++;
    bus_write(0, 3'd4, 32'hFFFF_FF0F);
    total++; if (out8 !== 8'hAF) $display("FAIL outset got %h exp af", out8); else passed++;
    bus_write(0, 3'd5, 32'h0000_0081);
    total++; if (out8 !== 8'h2E) $display("FAIL outclear got %h exp 2e", out8); else passed++;
    bus_write(0, 3'd1, 32'h0000_00FF);
    total++; if (oe8 !== 8'hFF) $display("FAIL dir_load got %h exp ff", oe8); else passed++;
    bus_read(0, 3'd0, d);
    total++; if (d !== 32'h0000_002E) $display("FAIL read_data_out got %h exp 0000002e", d); else passed++;
    bus_read(0, 3'd1, d);
    total++; if (d !== 32'h0000_00FF) $display("FAIL read_dir got %h exp 000000ff", d); else passed++;
  endtask

  task automatic test_input_read;
    logic [31:0] d;
    bus_write(0, 3'd1, 32'h0000_000F);
    bus_write(0, 3'd0, 32'h0000_0000);
    in8 = 8'hF0;
    wait_cycles(3);
    bus_read(0, 3'd0, d);
    total++; if (d !== 32'h0000_00F0) $display("FAIL read_mixed got %h exp 000000f0", d); else passed++;
    bus_read(0, 3'd6, d);
    total++; if (d !== 32'h0) $display("FAIL read_reserved6 got %h exp 0", d); else passed++;
    bus_read(0, 3'd4, d);
    total++; if (d !== 32'h0) $display("FAIL read_outset4 got %h exp 0", d); else passed++;
    bus_read(0, 3'd3, d);
    total++; if (d !== 32'h0000_00F0) $display("FAIL capture_any_dir got %h exp 000000f0", d); else passed++;
    bus_write(0, 3'd6, 32'hFFFF_FFFF);
    total++; if (out8 !== 8'h00) $display("FAIL wr6_out got %h exp 00", out8); else passed++;
    total++; if (oe8 !== 8'h0F) $display("FAIL wr6_oe got %h exp 0f", oe8); else passed++;
    bus_read(0, 3'd2, d);
    total++; if (d !== 32'h0) $display("FAIL wr6_mask got %h exp 0", d); else passed++;
    bus_write(0, 3'd3, 32'h0000_00FF);
    bus_read(0, 3'd3, d);
    total++; if (d !== 32'h0) $display("FAIL ec_clear_all got %h exp 0", d); else passed++;
  endtask

  task automatic test_rising_irq;
    bus_write(0, 3'd2, 32'h0000_0001);
    in8     = 8'hF1;
    address = 3'd3;
    wait_cycles(3);
    total++; if (rd8 !== 32'h0) $display("FAIL ec_early got %h exp 0", rd8); else passed++;
    total++; if (irq8 !== 1'b0) $display("FAIL irq_early got %b exp 0", irq8); else passed++;
    wait_cycles(1);
    total++; if (rd8 !== 32'h1) $display("FAIL ec_set got %h exp 1", rd8); else passed++;
    total++; if (irq8 !== 1'b1) $display("FAIL irq_set got %b exp 1", irq8); else passed++;
    bus_write(0, 3'd3, 32'h0000_0001);
    total++; if (irq8 !== 1'b1) $display("FAIL irq_hold_at_clear got %b exp 1", irq8); else passed++;
    wait_cycles(1);
    total++; if (irq8 !== 1'b0) $display("FAIL irq_after_clear got %b exp 0", irq8); else passed++;
  endtask

  task automatic test_set_wins;
    in8 = 8'hF0;
    wait_cycles(4);
    total++; if (irq8 !== 1'b0) $display("FAIL falling_no_irq got %b exp 0", irq8); else passed++;
    in8 = 8'hF1;
    wait_cycles(2);
    bus_write(0, 3'd3, 32'h0000_0001);
    wait_cycles(1);
    total++; if (rd8 !== 32'h1) $display("FAIL set_wins_ec got %h exp 1", rd8); else passed++;
    total++; if (irq8 !== 1'b1) $display("FAIL set_wins_irq got %b exp 1", irq8); else passed++;
    wait_cycles(1);
    total++; if (irq8 !== 1'b1) $display("FAIL set_wins_irq_hold got %b exp 1", irq8); else passed++;
  endtask

  task automatic test_reset_held_high;
    logic [31:0] d;
    in8       = 8'hFF;
    address   = 3'd0;
    writedata = 32'h0000_0055;
    cs8       = 1'b1;
    write_n   = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    cs8     = 1'b0;
    write_n = 1'b1;
    wait_cycles(1);
    reset = 1'b0;
    total++; if (out8 !== 8'h00) $display("FAIL write_during_reset got %h exp 00", out8); else passed++;
    total++; if (irq8 !== 1'b0) $display("FAIL reset_irq_clear got %b exp 0", irq8); else passed++;
    bus_write(0, 3'd2, 32'h0000_00FF);
    wait_cycles(8);
    bus_read(0, 3'd3, d);
    total++; if (d !== 32'h0) $display("FAIL held_high_ec got %h exp 0", d); else passed++;
    total++; if (irq8 !== 1'b0) $display("FAIL held_high_irq got %b exp 0", irq8); else passed++;
    in8 = 8'h7F;
    wait_cycles(5);
    bus_read(0, 3'd3, d);
    total++; if (d !== 32'h0) $display("FAIL rising_ignores_fall got %h exp 0", d); else passed++;
  endtask

  task automatic test_any_32;
    logic [31:0] d;
    in32 = 32'h8000_0000;
    wait_cycles(3);
    in32 = 32'h0000_0000;
    wait_cycles(5);
    bus_read(1, 3'd3, d);
    total++; if (d !== 32'h8000_0000) $display("FAIL any32_ec got %h exp 80000000", d); else passed++;
    total++; if (irq32 !== 1'b0) $display("FAIL any32_irq_masked got %b exp 0", irq32); else passed++;
    bus_write(1, 3'd3, 32'h8000_0000);
    bus_write(1, 3'd2, 32'h8000_0000);
    total++; if (irq32 !== 1'b0) $display("FAIL any32_cleared_irq got %b exp 0", irq32); else passed++;
    in32 = 32'h8000_0000;
    wait_cycles(5);
    bus_write(1, 3'd2, 32'h0000_0000);
    wait_cycles(2);
    total++; if (irq32 !== 1'b0) $display("FAIL any32_unmask_drop got %b exp 0", irq32); else passed++;
    bus_write(1, 3'd2, 32'h8000_0000);
    total++; if (irq32 !== 1'b0) $display("FAIL any32_mask_edge got %b exp 0", irq32); else passed++;
    wait_cycles(1);
    total++; if (irq32 !== 1'b1) $display("FAIL any32_mask_irq got %b exp 1", irq32); else passed++;
    bus_write(1, 3'd0, 32'hFFFF_FFFF);
    total++; if (out32 !== 32'hFFFF_FFFF) $display("FAIL any32_out got %h exp ffffffff", out32); else passed++;
  endtask

  initial begin
    passed    = 0;
    total     = 0;
    reset     = 1'b1;
    address   = 3'd0;
    cs8       = 1'b0;
    cs32      = 1'b0;
    write_n   = 1'b1;
    writedata = 32'h0;
    in8       = 8'h00;
    in32      = 32'h0;
    wait_cycles(3);
    test_reset;
    reset = 1'b0;
    wait_cycles(1);
    test_data_ops;
    test_input_read;
    test_rising_irq;
    test_set_wins;
    test_reset_held_high;
    test_any_32;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
